// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_pkg
//  Description : Shared RV32I decode definitions. Holds the opcode and
//                format-code constants, the buffer state encoding, and the
//                packed decoded-entry type used by both the main and the skid
//                register of id_operand_stage.
//  Config      : ID_MULDIV_EN adds the is_muldiv field to the decoded entry.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

  localparam int DATA_W = 32;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Instruction format codes
  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  // Two-entry buffer occupancy
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL1 = 2'd1,
    ST_FULL2 = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [11:0]       imm12;
    logic [DATA_W-1:0] imm;
    logic              opb_sel;
    logic [2:0]        fmt;
    logic              illegal;
`ifdef ID_MULDIV_EN
    logic              is_muldiv;
`endif
  } dec_entry_t;

endpackage
`default_nettype wire

// File: rtl/rv_imm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : rv_imm_gen
//  Description : Combinational RV32I immediate extender. Selects the
//                immediate layout by format code and sign-extends from
//                instr[31]. R and illegal formats yield zero.
//  Ports       : fmt   in  3   format code (rv_pkg FMT_*)
//                instr in  32  instruction word
//                imm   out 32  sign-extended immediate
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_imm_gen
  import rv_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  // Opcode and funct3 never contribute to an immediate.
  logic unused_bits;
  assign unused_bits = ^{instr[14:12], instr[6:0]};

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'b0};
      FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/id_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_operand_stage
//  Description : Registered RV32I decode stage between fetch and the execute
//                operand mux. Decodes register indices, immediates and the
//                operand-B select, and buffers up to two entries (main + skid)
//                so in_ready comes straight from a flop.
//  Ports       : clk, rst_n (async active-low), flush (sync, top priority)
//                in_valid/in_ready/in_instr/in_pc        - fetch side
//                out_valid/out_ready/out_pc/out_rs1/out_rs2/out_rd/
//                out_imm12/out_imm/out_opb_sel/out_fmt/out_illegal
//                out_is_muldiv                           - ID_MULDIV_EN only
//  Config      : ID_MULDIV_EN enables M-extension recognition on opcode OP.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_operand_stage
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [11:0]     out_imm12,
  output logic [XLEN-1:0] out_imm,
  output logic            out_opb_sel,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
`ifdef ID_MULDIV_EN
  ,
  output logic            out_is_muldiv
`endif
);

  buf_state_e state_q, state_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  dec_entry_t main_q, main_d;
  dec_entry_t skid_q, skid_d;
  dec_entry_t dec;

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  fmt;
  logic        opb_sel;
  logic        is_muldiv;
  logic [31:0] imm;
  logic        in_xfer;
  logic        out_xfer;

  // funct3 does not affect any decoded field here.
  logic unused_bits;
  assign unused_bits = ^in_instr[14:12];

  assign opcode = in_instr[6:0];
  assign funct7 = in_instr[31:25];

  always_comb begin
    fmt       = FMT_ILL;
    opb_sel   = 1'b0;
    is_muldiv = 1'b0;
    case (opcode)
      OP: begin
        if (funct7 == FUNCT7_MULDIV) begin
`ifdef ID_MULDIV_EN
          fmt       = FMT_R;
          opb_sel   = 1'b1;
          is_muldiv = 1'b1;
`else
          fmt       = FMT_ILL;
`endif
        end else begin
          fmt     = FMT_R;
          opb_sel = 1'b1;
        end
      end
      OP_IMM, LOAD, JALR: fmt = FMT_I;
      STORE:              fmt = FMT_S;
      BRANCH: begin
        fmt     = FMT_B;
        opb_sel = 1'b1;
      end
      LUI, AUIPC:         fmt = FMT_U;
      JAL:                fmt = FMT_J;
      default:            fmt = FMT_ILL;
    endcase
  end

  rv_imm_gen u_imm_gen (
    .fmt   (fmt),
    .instr (in_instr),
    .imm   (imm)
  );

  always_comb begin
    dec         = '0;
    dec.pc      = in_pc;
    dec.rs1     = in_instr[19:15];
    dec.rs2     = in_instr[24:20];
    // S and B formats reuse instr[11:7] as immediate bits, not a destination.
    dec.rd      = (fmt == FMT_S || fmt == FMT_B) ? 5'd0 : in_instr[11:7];
    dec.imm12   = in_instr[31:20];
    dec.imm     = imm;
    dec.opb_sel = opb_sel;
    dec.fmt     = fmt;
    dec.illegal = (fmt == FMT_ILL);
`ifdef ID_MULDIV_EN
    dec.is_muldiv = is_muldiv;
`endif
  end

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_d  = dec;
            state_d = ST_FULL1;
          end
        end
        ST_FULL1: begin
          if (in_xfer && out_xfer) begin
            main_d  = dec;
          end else if (in_xfer) begin
            skid_d  = dec;
            state_d = ST_FULL2;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL2: begin
          // in_ready is low here, so only the drain can happen.
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = ST_FULL1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d  = (state_d != ST_FULL2);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_pc      = main_q.pc;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_rd      = main_q.rd;
  assign out_imm12   = main_q.imm12;
  assign out_imm     = main_q.imm;
  assign out_opb_sel = main_q.opb_sel;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;
`ifdef ID_MULDIV_EN
  assign out_is_muldiv = main_q.is_muldiv;
`else
  logic unused_muldiv;
  assign unused_muldiv = is_muldiv;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_operand_stage
//  Description : Self-checking bench for id_operand_stage: a table of single
//                instructions with hand-decoded fields, then directed
//                sequences for backpressure, flush and asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [11:0] out_imm12;
  logic [31:0] out_imm;
  logic        out_opb_sel;
  logic [2:0]  out_fmt;
  logic        out_illegal;
`ifdef ID_MULDIV_EN
  logic        out_is_muldiv;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_operand_stage #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_rd      (out_rd),
    .out_imm12   (out_imm12),
    .out_imm     (out_imm),
    .out_opb_sel (out_opb_sel),
    .out_fmt     (out_fmt),
    .out_illegal (out_illegal)
`ifdef ID_MULDIV_EN
    ,
    .out_is_muldiv (out_is_muldiv)
`endif
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [11:0] imm12;
    logic [31:0] imm;
    logic        opb;
    logic [2:0]  fmt;
    logic        ill;
    logic        mdv;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(string n, logic [31:0] i, logic [31:0] p,
                              logic [4:0] r1, logic [4:0] r2, logic [4:0] d,
                              logic [11:0] i12, logic [31:0] im, logic ob,
                              logic [2:0] f, logic il, logic md);
    vec_t v;
    v.name = n; v.instr = i; v.pc = p; v.rs1 = r1; v.rs2 = r2; v.rd = d;
    v.imm12 = i12; v.imm = im; v.opb = ob; v.fmt = f; v.ill = il; v.mdv = md;
    return v;
  endfunction

  // Present one word at the negedge; it is accepted on the following posedge.
  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    // fmt codes: R=0 I=1 S=2 B=3 U=4 J=5 ILL=7
    vecs[0] = mk("addi", 32'hFFF10093, 32'h100, 5'd2, 5'd31, 5'd1, 12'hFFF, 32'hFFFFFFFF, 1'b0, 3'd1, 1'b0, 1'b0);
    vecs[1] = mk("add",  32'h002081B3, 32'h104, 5'd1, 5'd2,  5'd3, 12'h002, 32'h0,        1'b1, 3'd0, 1'b0, 1'b0);
    vecs[2] = mk("sw",   32'h00512423, 32'h108, 5'd2, 5'd5,  5'd0, 12'h005, 32'h8,        1'b0, 3'd2, 1'b0, 1'b0);
    vecs[3] = mk("lui",  32'h123452B7, 32'h10C, 5'd8, 5'd3,  5'd5, 12'h123, 32'h12345000, 1'b0, 3'd4, 1'b0, 1'b0);
    vecs[4] = mk("beq",  32'hFE208EE3, 32'h110, 5'd1, 5'd2,  5'd0, 12'hFE2, 32'hFFFFFFFC, 1'b1, 3'd3, 1'b0, 1'b0);
    vecs[5] = mk("jal",  32'h008000EF, 32'h114, 5'd0, 5'd8,  5'd1, 12'h008, 32'h8,        1'b0, 3'd5, 1'b0, 1'b0);
    vecs[6] = mk("ill",  32'hFFFFFFFF, 32'h118, 5'd31, 5'd31, 5'd31, 12'hFFF, 32'h0,      1'b0, 3'd7, 1'b1, 1'b0);
`ifdef ID_MULDIV_EN
    vecs[7] = mk("mul",  32'h022081B3, 32'h11C, 5'd1, 5'd2,  5'd3, 12'h022, 32'h0,        1'b1, 3'd0, 1'b0, 1'b1);
`else
    vecs[7] = mk("mul",  32'h022081B3, 32'h11C, 5'd1, 5'd2,  5'd3, 12'h022, 32'h0,        1'b0, 3'd7, 1'b1, 1'b0);
`endif

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_pc",    out_pc, 32'd0);
    chk("rst_out_imm",   out_imm, 32'd0);
    chk("rst_out_rd",    {27'd0, out_rd}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- decode table ----------------
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(vecs[i].instr, vecs[i].pc);
      @(negedge clk);
      in_valid = 1'b0;
      chk({vecs[i].name, "_valid"},   {31'd0, out_valid}, 32'd1);
      chk({vecs[i].name, "_pc"},      out_pc, vecs[i].pc);
      chk({vecs[i].name, "_rs1"},     {27'd0, out_rs1}, {27'd0, vecs[i].rs1});
      chk({vecs[i].name, "_rs2"},     {27'd0, out_rs2}, {27'd0, vecs[i].rs2});
      chk({vecs[i].name, "_rd"},      {27'd0, out_rd}, {27'd0, vecs[i].rd});
      chk({vecs[i].name, "_imm12"},   {20'd0, out_imm12}, {20'd0, vecs[i].imm12});
      chk({vecs[i].name, "_imm"},     out_imm, vecs[i].imm);
      chk({vecs[i].name, "_opb"},     {31'd0, out_opb_sel}, {31'd0, vecs[i].opb});
      chk({vecs[i].name, "_fmt"},     {29'd0, out_fmt}, {29'd0, vecs[i].fmt});
      chk({vecs[i].name, "_illegal"}, {31'd0, out_illegal}, {31'd0, vecs[i].ill});
`ifdef ID_MULDIV_EN
      chk({vecs[i].name, "_muldiv"},  {31'd0, out_is_muldiv}, {31'd0, vecs[i].mdv});
`endif
      @(negedge clk);
      chk({vecs[i].name, "_drained"}, {31'd0, out_valid}, 32'd0);
    end

    // ---------------- backpressure: A, B, C with out_ready=0 ----------------
    out_ready = 1'b0;
    push(32'h00100093, 32'hA00);               // A
    @(negedge clk);
    chk("bp_ready_after_A", {31'd0, in_ready}, 32'd1);
    chk("bp_head_A",        out_pc, 32'hA00);
    push(32'h00200093, 32'hB00);               // B
    @(negedge clk);
    chk("bp_ready_after_B", {31'd0, in_ready}, 32'd0);
    chk("bp_head_stable_1", out_pc, 32'hA00);
    push(32'h00300093, 32'hC00);               // C, held off
    @(negedge clk);
    chk("bp_C_held_ready",  {31'd0, in_ready}, 32'd0);
    chk("bp_head_stable_2", out_pc, 32'hA00);
    chk("bp_head_imm_A",    out_imm, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);                            // A leaves, B to main
    chk("bp_drain_B",       out_pc, 32'hB00);
    chk("bp_drain_B_imm",   out_imm, 32'd2);
    chk("bp_ready_reopen",  {31'd0, in_ready}, 32'd1);
    @(negedge clk);                            // B leaves, C accepted
    in_valid = 1'b0;
    chk("bp_drain_C",       out_pc, 32'hC00);
    chk("bp_drain_C_imm",   out_imm, 32'd3);
    @(negedge clk);                            // C leaves
    chk("bp_empty",         {31'd0, out_valid}, 32'd0);

    // ---------------- flush in FULL2 with a presented word ----------------
    out_ready = 1'b0;
    push(32'h00100093, 32'hD00);
    @(negedge clk);
    push(32'h00200093, 32'hD04);
    @(negedge clk);
    chk("fl2_full2", {31'd0, in_ready}, 32'd0);
    push(32'h00300093, 32'hD08);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl2_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl2_in_ready",  {31'd0, in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    chk("fl2_stays_empty", {31'd0, out_valid}, 32'd0);

    // ---------------- flush in FULL1 discards an accepted-looking word ------
    push(32'h00400093, 32'hE00);
    @(negedge clk);
    push(32'h00500093, 32'hE04);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl1_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl1_in_ready",  {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("fl1_dropped",   {31'd0, out_valid}, 32'd0);

    // ---------------- asynchronous reset mid-transfer ----------------
    push(32'h00600093, 32'hF00);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ar_loaded", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_out_pc",    out_pc, 32'd0);
    chk("ar_out_imm",   out_imm, 32'd0);
    chk("ar_in_ready",  {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("ar_post_empty", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Registered RISC-V RV32I instruction-decode stage. Sits between fetch and the execute operand mux.
- Takes raw 32-bit instruction words under valid/ready and extracts register indices and immediates.
- Generates the 12-bit immediate and the select that drive the ALU operand-B mux.
- Buffers up to two decoded entries so that in_ready is a pure register output.

Parameters:
- XLEN, 32, datapath width of the PC and the extended immediate; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush (branch or jump redirect)
- in_valid  in  1  instruction word present
- in_ready  out  1  stage can accept a word; registered
- in_instr  in  32  instruction word
- in_pc  in  XLEN  PC of in_instr
- out_valid  out  1  decoded entry present
- out_ready  in  1  execute accepts entry
- out_pc  out  XLEN  PC of the entry
- out_rs1  out  5  instr[19:15]
- out_rs2  out  5  instr[24:20]
- out_rd  out  5  instr[11:7]; forced to 0 for S/B types
- out_imm12  out  12  raw I-type immediate instr[31:20]; feeds the operand mux imm input
- out_imm  out  XLEN  fully sign-extended immediate for I/S/B/U/J formats
- out_opb_sel  out  1  1 = operand B from rs2 (R/B types); 0 = immediate
- out_fmt  out  3  format code, defined in the package
- out_illegal  out  1  unsupported opcode
- out_is_muldiv  out  1  M-extension op; present only with the macro

Behaviour:
- Reset (rst_n low, asynchronous):
  - in_ready=1, out_valid=0, buffer state EMPTY.
  - All data outputs = 0.
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Decode is combinational on in_instr and is captured at the input transfer.
  - Latency: one cycle from input transfer to out_valid.
- Immediate formats:
  - I: sign-extend instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Every format is sign-extended from instr[31].
  - R format: out_imm=0.
- Buffer state machine (main register plus skid register):
  - EMPTY: an input transfer goes to FULL1.
  - FULL1: input and output transfer together stay FULL1 (main reloads). Input only goes to FULL2 (skid loads). Output only goes to EMPTY.
  - FULL2: an output transfer moves skid to main and goes to FULL1. in_ready=0 in this state.
  - in_ready is registered: it is 0 exactly when the next state is FULL2.
- Ordering: strict FIFO. The output shows the oldest entry, and that entry is stable while out_valid && !out_ready.
- Flush:
  - Next state is EMPTY, out_valid=0, in_ready=1.
  - An input transfer in the same cycle is discarded.
  - Flush has priority over all other events.
- Illegal opcode:
  - The entry still passes through with out_illegal=1, out_opb_sel=0, out_imm=0.
  - The stage never stalls on it.
- Reset asserted mid-transfer: all entries are lost immediately; outputs take their reset values.

Optional Feature:
- Macro: ID_MULDIV_EN
- Defined:
  - Opcode OP with funct7=7'b0000001 sets out_is_muldiv=1, out_opb_sel=1, out_illegal=0.
  - out_is_muldiv is buffered like the other fields.
- Undefined:
  - The out_is_muldiv port is absent.
  - Such words set out_illegal=1.

Decomposition:
- Package rv_pkg holds:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR);
  - format codes FMT_R/I/S/B/U/J/ILL;
  - a packed struct for the decoded entry, so the main and skid registers are one type.
- One sub-module, rv_imm_gen: a combinational format-to-immediate extender, reused later by the branch unit.

Test Plan:
- addi x1,x2,-1 (0xFFF10093) with out_ready=1: next cycle out_rs1=2, out_rd=1, out_imm12=0xFFF, out_imm=0xFFFFFFFF, out_opb_sel=0.
- add x3,x1,x2 (0x002081B3): out_rs1=1, out_rs2=2, out_rd=3, out_opb_sel=1, out_imm=0.
- sw x5,8(x2) (0x00512423): out_fmt=S, out_imm=8, out_rs2=5, out_rd=0.
- Back-to-back words A, B, C with out_ready=0 for 3 cycles:
  - in_ready drops the cycle after B is accepted;
  - C is held off;
  - the drained order is A, B, C, with no loss or duplication.
- flush while in FULL2 with in_valid=1: next cycle out_valid=0, in_ready=1, and the presented word is dropped.
- mul x3,x1,x2 (0x022081B3):
  - with ID_MULDIV_EN: out_is_muldiv=1, out_illegal=0;
  - without it: out_illegal=1.
